// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the RV32 execute-stage ALU:
//   - DWIDTH_DEF : default operand/result width (32 is the supported value)
//   - alu_op_t   : 4-bit operation select type
//   - ALU_ADD .. ALU_AND : the ten defined opcodes (1010-1111 are undefined
//     and produce a zero result)
// Optional feature macro used by the ALU: ALU_STATUS_EN (adds status flags).
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int DWIDTH_DEF = 32;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_ADD  = 4'b0000;
  localparam alu_op_t ALU_SUB  = 4'b0001;
  localparam alu_op_t ALU_SLL  = 4'b0010;
  localparam alu_op_t ALU_SLT  = 4'b0011;
  localparam alu_op_t ALU_SLTU = 4'b0100;
  localparam alu_op_t ALU_XOR  = 4'b0101;
  localparam alu_op_t ALU_SRL  = 4'b0110;
  localparam alu_op_t ALU_SRA  = 4'b0111;
  localparam alu_op_t ALU_OR   = 4'b1000;
  localparam alu_op_t ALU_AND  = 4'b1001;

endpackage

// File: rtl/alu_shifter.sv
// -----------------------------------------------------------------------------
// alu_shifter
// Combinational barrel shifter for SLL / SRL / SRA.
// The shift amount is the FULL unsigned value of b_i; any amount >= DWIDTH
// saturates: left and logical-right give 0, arithmetic-right gives a copy of
// the sign bit in every position.
// Ports:
//   a_i     [DWIDTH-1:0]  value to shift
//   b_i     [DWIDTH-1:0]  shift amount (full width, not masked)
//   right_i               0 = shift left, 1 = shift right
//   arith_i               1 = arithmetic right shift (ignored for left)
//   res_o   [DWIDTH-1:0]  shifted result
// -----------------------------------------------------------------------------
module alu_shifter
  import alu_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic [DWIDTH-1:0] a_i,
  input  logic [DWIDTH-1:0] b_i,
  input  logic              right_i,
  input  logic              arith_i,
  output logic [DWIDTH-1:0] res_o
);

  localparam int                SW    = $clog2(DWIDTH);
  localparam logic [DWIDTH-1:0] LIMIT = DWIDTH'(DWIDTH);

  logic          sat;
  logic          fill;
  logic [SW-1:0] amt;

  // Amounts at or beyond the word width cannot be expressed by the low SW
  // bits, so they are detected on the full value and handled separately.
  assign sat  = (b_i >= LIMIT);
  assign fill = arith_i & a_i[DWIDTH-1];
  assign amt  = b_i[SW-1:0];

  always_comb begin
    res_o = '0;
    if (sat) begin
      res_o = right_i ? {DWIDTH{fill}} : '0;
    end else if (!right_i) begin
      res_o = a_i << amt;
    end else if (arith_i) begin
      res_o = $signed(a_i) >>> amt;
    end else begin
      res_o = a_i >> amt;
    end
  end

endmodule

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Single-cycle RV32 integer ALU. The result and zero flag are purely
// combinational from the operands and opcode; a registered copy (one cycle
// latency, no enable) is provided for pipelined consumers.
// Ports:
//   Clk              rising-edge clock (registered outputs only)
//   Reset_n          synchronous active-low reset of the registered outputs
//   ALU_In_A         operand A (rs1 / PC)
//   ALU_In_B         operand B (rs2 / immediate / full shift amount)
//   ALU_OP           4-bit operation select (see alu_pkg)
//   ALU_Out          combinational result
//   ALU_Zero_Flag    combinational, 1 when ALU_Out == 0
//   ALU_Out_Q        ALU_Out registered (reset value 0)
//   ALU_Zero_Flag_Q  ALU_Zero_Flag registered (reset value 1)
// Optional (macro ALU_STATUS_EN defined):
//   ALU_Neg_Flag / _Q    result sign bit
//   ALU_Carry_Flag / _Q  ADD carry-out, SUB not-borrow, else 0
//   ALU_Ovf_Flag / _Q    ADD/SUB signed overflow, else 0
//   Registered status flags reset to 0.
// -----------------------------------------------------------------------------
module alu_core
  import alu_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [DWIDTH-1:0] ALU_In_A,
  input  logic [DWIDTH-1:0] ALU_In_B,
  input  alu_op_t           ALU_OP,
  output logic [DWIDTH-1:0] ALU_Out,
  output logic              ALU_Zero_Flag,
  output logic [DWIDTH-1:0] ALU_Out_Q,
  output logic              ALU_Zero_Flag_Q
`ifdef ALU_STATUS_EN
  ,
  output logic              ALU_Neg_Flag,
  output logic              ALU_Carry_Flag,
  output logic              ALU_Ovf_Flag,
  output logic              ALU_Neg_Flag_Q,
  output logic              ALU_Carry_Flag_Q,
  output logic              ALU_Ovf_Flag_Q
`endif
);

  // ---------------------------------------------------------------------------
  // Shared adder: SUB is A + ~B + 1, so one carry chain serves both and its
  // carry-out is directly the NOT-borrow flag for SUB.
  // ---------------------------------------------------------------------------
  logic              is_sub;
  logic [DWIDTH-1:0] b_eff;
  logic [DWIDTH:0]   sum;

  assign is_sub = (ALU_OP == ALU_SUB);
  assign b_eff  = is_sub ? ~ALU_In_B : ALU_In_B;
  assign sum    = {1'b0, ALU_In_A} + {1'b0, b_eff} + {{DWIDTH{1'b0}}, is_sub};

  // ---------------------------------------------------------------------------
  // Compares and shifter
  // ---------------------------------------------------------------------------
  logic              lt_signed;
  logic              lt_unsigned;
  logic [DWIDTH-1:0] shift_res;

  assign lt_signed   = ($signed(ALU_In_A) < $signed(ALU_In_B));
  assign lt_unsigned = (ALU_In_A < ALU_In_B);

  alu_shifter #(
    .DWIDTH (DWIDTH)
  ) u_shifter (
    .a_i     (ALU_In_A),
    .b_i     (ALU_In_B),
    .right_i ((ALU_OP == ALU_SRL) || (ALU_OP == ALU_SRA)),
    .arith_i (ALU_OP == ALU_SRA),
    .res_o   (shift_res)
  );

  // ---------------------------------------------------------------------------
  // Result mux; undefined opcodes fall to the zero default.
  // ---------------------------------------------------------------------------
  logic [DWIDTH-1:0] alu_out_d;

  always_comb begin
    alu_out_d = '0;
    case (ALU_OP)
      ALU_ADD,
      ALU_SUB:  alu_out_d = sum[DWIDTH-1:0];
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  alu_out_d = shift_res;
      ALU_SLT:  alu_out_d = {{(DWIDTH-1){1'b0}}, lt_signed};
      ALU_SLTU: alu_out_d = {{(DWIDTH-1){1'b0}}, lt_unsigned};
      ALU_XOR:  alu_out_d = ALU_In_A ^ ALU_In_B;
      ALU_OR:   alu_out_d = ALU_In_A | ALU_In_B;
      ALU_AND:  alu_out_d = ALU_In_A & ALU_In_B;
      default:  alu_out_d = '0;
    endcase
  end

  logic zero_d;
  assign zero_d        = (alu_out_d == '0);
  assign ALU_Out       = alu_out_d;
  assign ALU_Zero_Flag = zero_d;

  // ---------------------------------------------------------------------------
  // Output registers. Reset loads a consistent "zero result" image.
  // ---------------------------------------------------------------------------
  logic [DWIDTH-1:0] alu_out_q;
  logic              zero_q;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      alu_out_q <= '0;
      zero_q    <= 1'b1;
    end else begin
      alu_out_q <= alu_out_d;
      zero_q    <= zero_d;
    end
  end

  assign ALU_Out_Q       = alu_out_q;
  assign ALU_Zero_Flag_Q = zero_q;

`ifdef ALU_STATUS_EN
  // ---------------------------------------------------------------------------
  // Status flags. Overflow: operands (after B inversion for SUB) share a sign
  // and the result sign differs from it.
  // ---------------------------------------------------------------------------
  logic is_addsub;
  logic neg_d;
  logic carry_d;
  logic ovf_d;
  logic neg_q;
  logic carry_q;
  logic ovf_q;

  assign is_addsub = (ALU_OP == ALU_ADD) || is_sub;
  assign neg_d     = alu_out_d[DWIDTH-1];
  assign carry_d   = is_addsub & sum[DWIDTH];
  assign ovf_d     = is_addsub
                   & (ALU_In_A[DWIDTH-1] == b_eff[DWIDTH-1])
                   & (sum[DWIDTH-1] != ALU_In_A[DWIDTH-1]);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      neg_q   <= neg_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ALU_Neg_Flag     = neg_d;
  assign ALU_Carry_Flag   = carry_d;
  assign ALU_Ovf_Flag     = ovf_d;
  assign ALU_Neg_Flag_Q   = neg_q;
  assign ALU_Carry_Flag_Q = carry_q;
  assign ALU_Ovf_Flag_Q   = ovf_q;
`else
  // Adder carry-out only feeds the status flags.
  logic unused_carry;
  assign unused_carry = sum[DWIDTH];
`endif

endmodule

// File: tb/tb_alu_core.sv
// -----------------------------------------------------------------------------
// tb_alu_core
// Self-checking bench for alu_core: directed vector table, register/reset
// sequences and 1000 random vectors against a behavioural reference model.
// Status-flag checks are compiled in when ALU_STATUS_EN is defined.
// -----------------------------------------------------------------------------
module tb_alu_core;

  localparam int W = 32;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [3:0]   op;
  logic [W-1:0] out_c;
  logic         zero_c;
  logic [W-1:0] out_q;
  logic         zero_q;
`ifdef ALU_STATUS_EN
  logic neg_c, carry_c, ovf_c, neg_q, carry_q, ovf_q;
`endif

  always #5 clk = ~clk;

  alu_core #(.DWIDTH(W)) dut (
    .Clk             (clk),
    .Reset_n         (rst_n),
    .ALU_In_A        (in_a),
    .ALU_In_B        (in_b),
    .ALU_OP          (op),
    .ALU_Out         (out_c),
    .ALU_Zero_Flag   (zero_c),
    .ALU_Out_Q       (out_q),
    .ALU_Zero_Flag_Q (zero_q)
`ifdef ALU_STATUS_EN
    ,
    .ALU_Neg_Flag     (neg_c),
    .ALU_Carry_Flag   (carry_c),
    .ALU_Ovf_Flag     (ovf_c),
    .ALU_Neg_Flag_Q   (neg_q),
    .ALU_Carry_Flag_Q (carry_q),
    .ALU_Ovf_Flag_Q   (ovf_q)
`endif
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [W-1:0] out;
    logic         c;
    logic         v;
  } model_t;

  model_t exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: straight from the operation rules, using wide signed
  // integers for compare/overflow and explicit saturation for big shifts.
  // ---------------------------------------------------------------------------
  function automatic model_t ref_alu(input logic [3:0] f_op, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
    model_t      m;
    longint      sa;
    longint      sb;
    longint      r;
    logic [32:0] s33;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    m  = '0;
    case (f_op)
      4'd0: begin
        m.out = a + b;
        s33   = {1'b0, a} + {1'b0, b};
        m.c   = s33[32];
        r     = sa + sb;
        m.v   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      4'd1: begin
        m.out = a - b;
        m.c   = (a >= b);
        r     = sa - sb;
        m.v   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      4'd2: m.out = (b >= 32) ? '0 : (a << b);
      4'd3: m.out = (sa < sb) ? 32'd1 : 32'd0;
      4'd4: m.out = (a < b) ? 32'd1 : 32'd0;
      4'd5: m.out = a ^ b;
      4'd6: m.out = (b >= 32) ? '0 : (a >> b);
      4'd7: begin
        if (b >= 32) m.out = a[31] ? '1 : '0;
        else         m.out = W'(sa >>> b);
      end
      4'd8: m.out = a | b;
      4'd9: m.out = a & b;
      default: m.out = '0;
    endcase
    return m;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: apply one vector after the falling edge, check the combinational
  // outputs 1 ns later, then check the registered copy just after the next
  // rising edge.
  // ---------------------------------------------------------------------------
  task automatic apply(input string name, input logic [3:0] t_op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input model_t exp);
    model_t e;
    @(negedge clk);
    op   = t_op;
    in_a = a;
    in_b = b;
    #1;
    check({name, ".out"},  out_c, exp.out);
    check({name, ".zero"}, W'(zero_c), W'(exp.out == '0));
`ifdef ALU_STATUS_EN
    check({name, ".neg"},   W'(neg_c),   W'(exp.out[W-1]));
    check({name, ".carry"}, W'(carry_c), W'(exp.c));
    check({name, ".ovf"},   W'(ovf_c),   W'(exp.v));
`endif
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({name, ".out_q"},  out_q, e.out);
    check({name, ".zero_q"}, W'(zero_q), W'(e.out == '0));
`ifdef ALU_STATUS_EN
    check({name, ".neg_q"},   W'(neg_q),   W'(e.out[W-1]));
    check({name, ".carry_q"}, W'(carry_q), W'(e.c));
    check({name, ".ovf_q"},   W'(ovf_q),   W'(e.v));
`endif
  endtask

  function automatic model_t mk(input logic [W-1:0] o, input logic c, input logic v);
    model_t m;
    m.out = o;
    m.c   = c;
    m.v   = v;
    return m;
  endfunction

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_out;
    logic         exp_c;
    logic         exp_v;
  } vec_t;

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{"add_wrap",  4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    vecs[1]  = '{"sub_neg",   4'b0001, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[2]  = '{"slt",       4'b0011, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
    vecs[3]  = '{"sltu",      4'b0100, 32'h80000000, 32'h00000001, 32'h00000000, 1'b0, 1'b0};
    vecs[4]  = '{"sltu_eq",   4'b0100, 32'h00000003, 32'h00000003, 32'h00000000, 1'b0, 1'b0};
    vecs[5]  = '{"sll4",      4'b0010, 32'h80000010, 32'h00000004, 32'h00000100, 1'b0, 1'b0};
    vecs[6]  = '{"srl4",      4'b0110, 32'h80000010, 32'h00000004, 32'h08000001, 1'b0, 1'b0};
    vecs[7]  = '{"sra4",      4'b0111, 32'h80000010, 32'h00000004, 32'hF8000001, 1'b0, 1'b0};
    vecs[8]  = '{"sra32",     4'b0111, 32'h80000010, 32'h00000020, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[9]  = '{"srl_big",   4'b0110, 32'h80000010, 32'h12345678, 32'h00000000, 1'b0, 1'b0};
    vecs[10] = '{"xor",       4'b0101, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0};
    vecs[11] = '{"or",        4'b1000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0};
    vecs[12] = '{"and",       4'b1001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
    vecs[13] = '{"undef_c",   4'b1100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h00000000, 1'b0, 1'b0};
    vecs[14] = '{"add_ovf",   4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    model_t m;
    logic [3:0]   r_op;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;

    // Reset held for one edge with a nonzero result on the inputs.
    rst_n = 1'b0;
    op    = 4'b0000;
    in_a  = 32'd1;
    in_b  = 32'd1;
    @(posedge clk);
    #1;
    check("rst.out_q",  out_q, 32'h0);
    check("rst.zero_q", W'(zero_q), 32'h1);
    check("rst.out_comb", out_c, 32'h2);
`ifdef ALU_STATUS_EN
    check("rst.flags_q", {29'h0, neg_q, carry_q, ovf_q}, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 15; i++) begin
      apply(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
            mk(vecs[i].exp_out, vecs[i].exp_c, vecs[i].exp_v));
    end

    // ADD 2+3 then reset mid-stream with inputs held.
    apply("add_2_3", 4'b0000, 32'd2, 32'd3, mk(32'd5, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst.out_q",  out_q, 32'h0);
    check("midrst.zero_q", W'(zero_q), 32'h1);
    check("midrst.out_comb",  out_c, 32'd5);
    check("midrst.zero_comb", W'(zero_c), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("postrst.out_q", out_q, 32'd5);

    // Random vectors; half of them use small B so shifts stay interesting.
    for (int i = 0; i < 1000; i++) begin
      r_op = 4'($urandom_range(0, 15));
      r_a  = $urandom;
      r_b  = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 40)) : $urandom;
      m    = ref_alu(r_op, r_a, r_b);
      apply("rand", r_op, r_a, r_b, m);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
